status_flag_unit: RTL

Producer side of the condition-flag interface: derives N, ZF, C and V from ALU/shifter results, holds them in the architectural status register, and drives them to the condition tester. Flag updates pass through a one-entry pending stage, with an optional bypass so a condition evaluated in the cycle after an S-instruction sees the new flags. It also provides the saved-flags copy used on exception entry and return, plus direct MSR-style writes.

---
 rtl/status_flag_unit_pkg.sv | 32 +++
 rtl/status_flag_unit_flag_gen.sv | 32 +++
 rtl/status_flag_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/status_flag_unit_pkg.sv
// Shared definitions for the condition-flag producer and the condition tester.
// Contents: flag bit positions inside a {N,ZF,C,V} nibble and the 4-bit
// condition-code encodings.
package status_flag_unit_pkg;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Condition codes evaluated by the condition tester against {N,ZF,C,V}.
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/status_flag_unit_flag_gen.sv
// Combinational NZCV derivation from an ALU/shifter result.
// Ports:
//   result        ALU result
//   carry_out     ALU carry out (arithmetic ops)
//   overflow      ALU signed overflow (arithmetic ops)
//   shifter_carry shifter carry out (logical ops)
//   logical       logical op select
//   v_keep        V value preserved by logical ops
//   flags_c       generated {N,ZF,C,V}
module status_flag_unit_flag_gen
  import status_flag_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]  result,
  input  logic              carry_out,
  input  logic              overflow,
  input  logic              shifter_carry,
  input  logic              logical,
  input  logic              v_keep,
  output logic [FLAG_W-1:0] flags_c
);

  always_comb begin
    flags_c         = '0;
    flags_c[FLAG_N] = result[WIDTH-1];
    flags_c[FLAG_Z] = (result == '0);
    flags_c[FLAG_C] = logical ? shifter_carry : carry_out;
    flags_c[FLAG_V] = logical ? v_keep : overflow;
  end

endmodule

// File: rtl/status_flag_unit.sv
// Architectural status register: one-entry pending stage for S updates,
// optional bypass of the pending entry to the outputs, saved-flags copy for
// exception entry/return, and direct flag writes.
// Ports:
//   Clk, Reset                    clock, synchronous active-low reset
//   Result, CarryOut, Overflow,
//   ShifterCarry, Logical, S      flag-update request and its sources
//   FlagWrite, FlagData           direct write of {N,ZF,C,V}
//   Save, Restore                 saved-flags copy / reload (swap if both)
//   N, ZF, C, V                   visible flags (registered)
//   SavedFlags                    saved {N,ZF,C,V}
//   Pending                       pending stage holds an update
module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WIDTH-1:0]  Result,
  input  logic              CarryOut,
  input  logic              Overflow,
  input  logic              ShifterCarry,
  input  logic              Logical,
  input  logic              S,
  input  logic              FlagWrite,
  input  logic [FLAG_W-1:0] FlagData,
  input  logic              Save,
  input  logic              Restore,
  output logic              N,
  output logic              ZF,
  output logic              C,
  output logic              V,
  output logic [FLAG_W-1:0] SavedFlags,
  output logic              Pending
);

  logic [FLAG_W-1:0] commit_q, commit_d;
  logic [FLAG_W-1:0] pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [FLAG_W-1:0] saved_q, saved_d;
  logic [FLAG_W-1:0] vis_q, vis_d;
  logic [FLAG_W-1:0] gen_flags_c;

  // Logical ops keep the V currently seen by the condition tester.
  status_flag_unit_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result        (Result),
    .carry_out     (CarryOut),
    .overflow      (Overflow),
    .shifter_carry (ShifterCarry),
    .logical       (Logical),
    .v_keep        (vis_q[FLAG_V]),
    .flags_c       (gen_flags_c)
  );

  // Next-state: Restore > FlagWrite > pending commit/capture.
  always_comb begin
    commit_d     = commit_q;
    pend_d       = pend_q;
    pend_valid_d = 1'b0;
    saved_d      = saved_q;

    if (Save) saved_d = vis_q;

    if (Restore) begin
      commit_d = saved_q;
    end else if (FlagWrite) begin
      commit_d = FlagData;
    end else begin
      if (pend_valid_q) commit_d = pend_q;
      if (S) begin
        pend_d       = gen_flags_c;
        pend_valid_d = 1'b1;
      end
    end

    // Visible flags are registered from next-state, so outputs are pure flops.
    vis_d = (BYPASS && pend_valid_d) ? pend_d : commit_d;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      commit_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      saved_q      <= '0;
      vis_q        <= '0;
    end else begin
      commit_q     <= commit_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      saved_q      <= saved_d;
      vis_q        <= vis_d;
    end
  end

  assign N          = vis_q[FLAG_N];
  assign ZF         = vis_q[FLAG_Z];
  assign C          = vis_q[FLAG_C];
  assign V          = vis_q[FLAG_V];
  assign SavedFlags = saved_q;
  assign Pending    = pend_valid_q;

endmodule
